// File: rtl/adc_seq_pkg.sv
// Shared types and framing constants for the ADC frame sequencer.
// Holds the FSM state enum, frame/slot geometry and the WCLK window.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int WCLK_FIRST = 1;
  localparam int WCLK_LAST  = 16;

  localparam int SLOT_W  = $clog2(SLOT_BITS);
  localparam int FRAME_W = $clog2(FRAME_BITS);

  function automatic logic wclk_on(
    input logic [SLOT_W-1:0] s
  );
    return (s >= SLOT_W'(WCLK_FIRST)) &&
           (s <= SLOT_W'(WCLK_LAST));
  endfunction

endpackage

// File: rtl/adc_frame_sequencer_bclk_div.sv
// BCLK divider: counts 0..BCLK_DIV-1 and toggles bclk at the terminal count.
// Ports: clk, reset, clear (sync), en -> bclk, bclk_fall (1-cycle strobe).
module adc_bclk_div #(
  parameter int BCLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bclk,
  output logic bclk_fall
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(BCLK_DIV - 1));

  // Combinational so framing can advance on the very edge bclk drops.
  assign bclk_fall = tick && bclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (en) begin
      if (tick) begin
        cnt  <= '0;
        bclk <= ~bclk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_frame_sequencer.sv
// Master-mode ADC framing (BCLK/LRCK/WCLK), per-frame L/R capture, and a
// valid/ready output stage with sticky overrun. Ports: clk, reset, enable,
// clear_overrun, adc_left/right -> bclk, lrck, wclk, sample_*, overrun, busy.
module adc_frame_sequencer
  import adc_seq_pkg::*;
#(
  parameter int BCLK_DIV  = 1,
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_overrun,
  input  logic [WORD_BITS-1:0] adc_left,
  input  logic [WORD_BITS-1:0] adc_right,
  output logic                 bclk,
  output logic                 lrck,
  output logic                 wclk,
  output logic [WORD_BITS-1:0] sample_left,
  output logic [WORD_BITS-1:0] sample_right,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 busy
);

  state_e             state;
  logic [FRAME_W-1:0] b;
  logic               first;
  logic               fall;
  logic               wrap;
  logic               hs;

  adc_bclk_div #(
    .BCLK_DIV (BCLK_DIV)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == IDLE),
    .en        (state != IDLE),
    .bclk      (bclk),
    .bclk_fall (fall)
  );

  // The first fall opens b=0 rather than advancing past it.
  assign wrap = fall && !first &&
                (b == FRAME_W'(FRAME_BITS - 1));
  assign hs   = sample_valid && sample_ready;

  assign busy = (state != IDLE);
  assign lrck = (b < FRAME_W'(SLOT_BITS));
  assign wclk = wclk_on(b[SLOT_W-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      b     <= '0;
      first <= 1'b1;
    end else begin
      if (fall) begin
        if (first) first <= 1'b0;
        else       b     <= b + 1'b1;
      end
      unique case (state)
        IDLE: begin
          b     <= '0;
          first <= 1'b1;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (wrap)         state <= enable ? RUN : IDLE;
          else if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (wrap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // A handshake in the capture cycle frees the slot for the new pair.
      if (wrap && (!sample_valid || sample_ready)) begin
        sample_left  <= adc_left;
        sample_right <= adc_right;
        sample_valid <= 1'b1;
      end else if (hs) begin
        sample_valid <= 1'b0;
      end
      if (wrap && sample_valid && !sample_ready)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: doc/adc_frame_sequencer.md
# adc_frame_sequencer

Master-mode sequencer for the serial ADC receiver. Generates BCLK, LRCK and WCLK framing from the system clock, starts and stops framing cleanly on frame boundaries, and captures the receiver's parallel left/right words once per frame. Presents each captured pair downstream through a valid/ready handshake with overrun detection. Sits between the ADC receiver and the channel-strip processing chain.

## Interface
- `BCLK_DIV`, default 1: number of clk cycles per BCLK half-period; legal range ≥ 1.
- `WORD_BITS`, default 16: sample width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  request framing; sampled each clk.
- `clear_overrun`  in  1  one-cycle pulse that clears `overrun`.
- `adc_left`  in  WORD_BITS  signed left word from the receiver.
- `adc_right`  in  WORD_BITS  signed right word from the receiver.
- `bclk`  out  1  bit clock to the receiver.
- `lrck`  out  1  channel select: 1 = left slot, 0 = right slot.
- `wclk`  out  1  word-valid window: high during the 16 data bits.
- `sample_left`  out  WORD_BITS  captured left word.
- `sample_right`  out  WORD_BITS  captured right word.
- `sample_valid`  out  1  captured pair available.
- `sample_ready`  in  1  downstream accepts the pair.
- `overrun`  out  1  sticky: a pair was dropped.
- `busy`  out  1  high in RUN or DRAIN.

## Operation
- Frame = 64 BCLK periods, indexed b = 0..63. Slot s = b mod 32.
- `lrck` = 1 for b 0..31 and 0 for b 32..63.
- `wclk` = 1 for s 1..16, otherwise 0. Gives a one-bit delay after each LRCK edge, 16 data bits, then 15 idle bits.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE → RUN when `enable`=1. The divider starts, and b=0 begins on the first BCLK falling edge.
  - RUN → DRAIN when `enable`=0 mid-frame. DRAIN completes the frame in progress.
  - RUN stays RUN at the frame wrap if `enable`=1. It goes to IDLE at the frame wrap if `enable`=0.
  - DRAIN → IDLE at the end of b=63. DRAIN ignores a re-asserted `enable` until IDLE is reached.
- Capture happens at the falling edge ending b=63. `adc_left` and `adc_right` are registered into `sample_left` and `sample_right`. The final frame in DRAIN is also captured.
- Handshake:
  - `sample_valid` rises with a capture and holds until `sample_valid`&&`sample_ready`.
  - Data is stable while valid.
- Capture while valid and not ready:
  - The new pair is dropped.
  - The old pair is kept.
  - `overrun` is set.
- Capture in the same cycle as a handshake: the new pair is loaded, `sample_valid` stays 1, and no overrun occurs.
- `overrun` clears on `clear_overrun`. If set and clear coincide, set wins.

## Timing
- Divider: a counter runs 0..BCLK_DIV-1 and `bclk` toggles when it reaches BCLK_DIV-1. With the default, `bclk` toggles every clk.
- `lrck`, `wclk` and b update in the same clk as the 1→0 toggle of `bclk`. Receiver data is therefore stable around the BCLK rising edge.
- Frame length is 128·BCLK_DIV clk cycles.
- Capture to `sample_valid`=1 is 1 clk, registered on the edge that ends b=63.
- Reset and IDLE values:
  - `bclk`=0, `lrck`=1, `wclk`=0.
  - `sample_left`=`sample_right`=0.
  - `sample_valid`=0, `overrun`=0, `busy`=0.
  - Divider and b are cleared.
- Reset mid-frame returns everything to reset values immediately (asynchronous). No partial pair is presented.
- In IDLE, `bclk` is held at 0 with no toggling.

## Structure
- Package `adc_seq_pkg` holds:
  - the state enum {IDLE, RUN, DRAIN};
  - SLOT_BITS=32, FRAME_BITS=64;
  - WCLK_FIRST=1, WCLK_LAST=16.
- Sub-module `adc_bclk_div` produces the divider counter, `bclk`, and a one-cycle `bclk_fall` strobe. It is reset and enabled by the FSM.
- The top level contains the FSM, bit counter, framing decode, capture register, handshake and overrun logic.

## Test plan
- Reset, then `enable`=1 with BCLK_DIV=1:
  - first `bclk` fall at clk 2;
  - `wclk` high for exactly 16 BCLK in each slot;
  - `lrck` toggles every 32 BCLK;
  - frame = 128 clk.
- Receiver model driving left=0x0009 and right=0x0006, with `sample_ready`=1: each frame yields `sample_left`=0x0009 and `sample_right`=0x0006, with `sample_valid` high for 1 clk and `overrun`=0.
- `sample_ready`=0 for 2 frames with left=0x1234 then 0x5678: `sample_left` stays 0x1234, `overrun`=1 after the second capture, and `clear_overrun` returns it to 0.
- `sample_ready` asserted in the exact capture cycle: the new pair is loaded, `sample_valid` stays 1, and `overrun` stays 0.
- `enable` dropped at b=10: framing continues to b=63, the pair is captured, then IDLE with `bclk`=0, `lrck`=1 and `busy`=0. Re-asserting `enable` during DRAIN has no effect until IDLE.
- `reset` pulsed at b=40 with BCLK_DIV=3: all outputs are at reset values in the same cycle, and no `sample_valid` occurs for the aborted frame.
